// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module      : load_store_unit_if
// Description : Bundles the three buses of the load/store unit: the upstream
//               request channel, the downstream response channel and the
//               data-side memory port.
//               slave  : view taken by load_store_unit
//               master : view taken by the execute stage / memory model
// Ports       : none (signals are reached through the modports)
//   req_*  : valid/ready request (type, funct3, byte address, store data)
//   resp_* : valid/ready response (extended load data, error flag)
//   mem_*  : word-indexed read/write strobes, index, write word, read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_is_load;
  logic        mem_is_store;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic [31:0] mem_load_data;

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_is_load, mem_is_store, mem_addr, mem_store_data,
    input  mem_load_data
  );

  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_is_load, mem_is_store, mem_addr, mem_store_data,
    output mem_load_data
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store unit. Turns byte-addressed LB/LH/LW/LBU/LHU/
//               SB/SH/SW requests into whole-word memory accesses. Sub-word
//               stores are read-modify-write; load data is lane-selected and
//               sign/zero-extended. Malformed, misaligned and out-of-range
//               requests are answered with resp_err and never reach memory.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - load_store_unit_if.slave (request, response, memory)
// Parameters  : ADDR_WIDTH - word-index width of the data memory
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  load_store_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] c_SZ_B = 2'b00;
  localparam logic [1:0] c_SZ_H = 2'b01;
  localparam logic [1:0] c_SZ_W = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;          // addr[1:0] of the accepted request
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] wdata_q, wdata_d;        // only the low half feeds SB/SH merges
  logic        is_store_q, is_store_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] store_data_q, store_data_d;

  // --------------------------------------------------------------------------
  // Request validation, evaluated on the incoming request
  // --------------------------------------------------------------------------
  logic w_type_bad, w_ld_f3_ok, w_st_f3_ok, w_f3_bad, w_misalign, w_oor, w_err;

  always_comb begin
    w_type_bad = (bus.req_is_load == bus.req_is_store);
    // Loads allow 000,001,010,100,101; stores allow 000,001,010.
    w_ld_f3_ok = (bus.req_funct3[1:0] != 2'b11) && (bus.req_funct3 != 3'b110);
    w_st_f3_ok = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
    w_f3_bad   = bus.req_is_store ? !w_st_f3_ok : !w_ld_f3_ok;
    w_misalign = ((bus.req_funct3[1:0] == c_SZ_H) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == c_SZ_W) && (bus.req_addr[1:0] != 2'b00));
    w_oor      = ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    w_err      = w_type_bad || w_f3_bad || w_misalign || w_oor;
  end

  // --------------------------------------------------------------------------
  // Lane extraction and sub-word merge on the word read in RD
  // --------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext, w_merged;

  always_comb begin
    case (lane_q)
      2'd0:    w_byte = bus.mem_load_data[7:0];
      2'd1:    w_byte = bus.mem_load_data[15:8];
      2'd2:    w_byte = bus.mem_load_data[23:16];
      default: w_byte = bus.mem_load_data[31:24];
    endcase
    w_half = lane_q[1] ? bus.mem_load_data[31:16] : bus.mem_load_data[15:0];

    // funct3[2] selects zero extension (BU/HU)
    case (funct3_q[1:0])
      c_SZ_B:  w_load_ext = funct3_q[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      c_SZ_H:  w_load_ext = funct3_q[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = bus.mem_load_data;
    endcase

    w_merged = bus.mem_load_data;
    if (funct3_q[1:0] == c_SZ_B) begin
      case (lane_q)
        2'd0:    w_merged[7:0]   = wdata_q[7:0];
        2'd1:    w_merged[15:8]  = wdata_q[7:0];
        2'd2:    w_merged[23:16] = wdata_q[7:0];
        default: w_merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      w_merged[31:16] = wdata_q;
    end else begin
      w_merged[15:0]  = wdata_q;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    is_store_d   = is_store_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    store_data_d = store_data_q;

    // Strobes come from state alone so an async reset kills them at once.
    bus.req_ready      = (state_q == IDLE);
    bus.resp_valid     = (state_q == RESP);
    bus.resp_rdata     = rdata_q;
    bus.resp_err       = err_q;
    bus.mem_is_load    = (state_q == RD);
    bus.mem_is_store   = (state_q == WR);
    bus.mem_addr       = mem_addr_q;
    bus.mem_store_data = store_data_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          lane_d     = bus.req_addr[1:0];
          funct3_d   = bus.req_funct3;
          wdata_d    = bus.req_wdata[15:0];
          is_store_d = bus.req_is_store;
          rdata_d    = 32'd0;
          if (w_err) begin
            // Memory index is left untouched: errors have no side effect.
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d      = 1'b0;
            mem_addr_d = 32'(bus.req_addr[ADDR_WIDTH+1:2]);
            if (bus.req_is_store && (bus.req_funct3[1:0] == c_SZ_W)) begin
              store_data_d = bus.req_wdata;
              state_d      = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (is_store_q) begin
          store_data_d = w_merged;
          state_d      = WR;
        end else begin
          rdata_d = w_load_ext;
          state_d = RESP;
        end
      end
      WR: begin
        state_d = RESP;
      end
      default: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lane_q       <= 2'd0;
      funct3_q     <= 3'd0;
      wdata_q      <= 16'd0;
      is_store_q   <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      mem_addr_q   <= 32'd0;
      store_data_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      is_store_q   <= is_store_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      store_data_q <= store_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a 4K-word memory
//               model, a request table and hand-written hold/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic clk;
  logic rst_n;

  load_store_unit_if bus ();

  load_store_unit #(.ADDR_WIDTH(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Memory model: combinational read, write on rising edge
  // --------------------------------------------------------------------------
  logic [31:0] mem [0:4095];
  int          st_cnt;
  int          ld_cnt;
  logic [31:0] last_st_addr;
  logic [31:0] last_st_data;

  assign bus.mem_load_data = mem[bus.mem_addr[11:0]];

  always @(posedge clk) begin
    if (bus.mem_is_store) begin
      mem[bus.mem_addr[11:0]] <= bus.mem_store_data;
      st_cnt       <= st_cnt + 1;
      last_st_addr <= bus.mem_addr;
      last_st_data <= bus.mem_store_data;
    end
    if (bus.mem_is_load) ld_cnt <= ld_cnt + 1;
  end

  // --------------------------------------------------------------------------
  // Checking helpers and scoreboard
  // --------------------------------------------------------------------------
  int n_chk;
  int n_fail;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wword;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic err, input int lat,
                     input int nrd, input int nwr, input logic [31:0] wword);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    v.wword = wword;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_is_load  = ld;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  // Issues one request, waits (bounded) for its response, scores it and
  // completes the response handshake.
  task automatic do_req(input string tag, input vec_t v);
    int   st0;
    int   ld0;
    int   lat;
    exp_t e;
    exp_t ne;
    st0 = st_cnt;
    ld0 = ld_cnt;
    ne.rdata = v.rdata; ne.err = v.err; ne.lat = v.lat;
    exp_q.push_back(ne);
    @(negedge clk);
    chk({tag, " req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    drive(v.ld, v.st, v.f3, v.addr, v.wdata);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      chk({tag, " req_ready_busy"}, 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.resp_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: resp_valid=0 after %0d cycles, expected 1", tag, lat);
    end
    e = exp_q.pop_front();
    chk({tag, " rdata"}, bus.resp_rdata, e.rdata);
    chk({tag, " err"}, 32'(bus.resp_err), 32'(e.err));
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk({tag, " resp_valid_drop"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, " store_pulses"}, 32'(st_cnt - st0), 32'(v.nwr));
    chk({tag, " load_pulses"}, 32'(ld_cnt - ld0), 32'(v.nrd));
    if (v.nwr == 1) begin
      chk({tag, " store_index"}, last_st_addr, {20'd0, v.addr[13:2]});
      chk({tag, " store_word"}, last_st_data, v.wword);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    vec_t        v;
    logic [31:0] held;
    int          ld0;
    int          st0;
    int          w;

    n_chk = 0;
    n_fail = 0;
    st_cnt = 0;
    ld_cnt = 0;
    last_st_addr = '0;
    last_st_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h010] = 32'h8070F0A5;
    mem[12'h012] = 32'h11223344;
    mem[12'hFFF] = 32'hCAFEF00D;

    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_is_load = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    bus.resp_ready = 1'b0;

    // Reset state
    #3;
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst strobes", {30'd0, bus.mem_is_load, bus.mem_is_store}, 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_store_data", bus.mem_store_data, 32'd0);
    #9;
    rst_n = 1'b1;

    //  ld    st    f3      addr          wdata         rdata         err lat rd wr wword
    add(1'b1, 1'b0, 3'b000, 32'h00000043, 32'h0,        32'hFFFFFF80, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b100, 32'h00000043, 32'h0,        32'h00000080, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b001, 32'h00000042, 32'h0,        32'hFFFF8070, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b101, 32'h00000042, 32'h0,        32'h00008070, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b010, 32'h00000040, 32'h0,        32'h8070F0A5, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b000, 32'h00000040, 32'h0,        32'hFFFFFFA5, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b100, 32'h00000041, 32'h0,        32'h000000F0, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b001, 32'h00000040, 32'h0,        32'hFFFFF0A5, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b010, 32'h00000042, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    add(1'b0, 1'b1, 3'b001, 32'h00000041, 32'h1234,     32'h0,        1, 1, 0, 0, 32'h0);
    add(1'b1, 1'b0, 3'b011, 32'h00000040, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    add(1'b1, 1'b1, 3'b010, 32'h00000040, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    add(1'b0, 1'b0, 3'b010, 32'h00000040, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    add(1'b1, 1'b0, 3'b010, 32'h00004000, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    add(1'b0, 1'b1, 3'b100, 32'h00000040, 32'h5A,       32'h0,        1, 1, 0, 0, 32'h0);
    add(1'b1, 1'b0, 3'b101, 32'h00000043, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    add(1'b0, 1'b1, 3'b000, 32'h00000041, 32'h0000005A, 32'h0,        0, 3, 1, 1, 32'h80705AA5);
    add(1'b1, 1'b0, 3'b010, 32'h00000040, 32'h0,        32'h80705AA5, 0, 2, 1, 0, 32'h0);
    add(1'b0, 1'b1, 3'b001, 32'h00000042, 32'h00001234, 32'h0,        0, 3, 1, 1, 32'h12345AA5);
    add(1'b0, 1'b1, 3'b010, 32'h00000044, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 32'hDEADBEEF);
    add(1'b1, 1'b0, 3'b010, 32'h00000040, 32'h0,        32'h12345AA5, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b010, 32'h00000044, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'h0);
    add(1'b1, 1'b0, 3'b010, 32'h00003FFC, 32'h0,        32'hCAFEF00D, 0, 2, 1, 0, 32'h0);

    foreach (vecs[i]) do_req($sformatf("vec%0d", i), vecs[i]);

    // Response held for 5 cycles while another request is waiting upstream
    ld0 = ld_cnt;
    exp_q.push_back('{32'hDEADBEEF, 1'b0, 2});
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h00000044, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 3'b010, 32'h00000040, 32'h0);
    w = 0;
    while (!bus.resp_valid && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    begin
      exp_t e;
      e = exp_q.pop_front();
      chk("hold rdata", bus.resp_rdata, e.rdata);
      chk("hold latency", 32'(w + 1), 32'(e.lat));
    end
    held = bus.resp_rdata;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold c%0d resp_valid", c), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("hold c%0d rdata", c), bus.resp_rdata, held);
      chk($sformatf("hold c%0d err", c), 32'(bus.resp_err), 32'd0);
      chk($sformatf("hold c%0d req_ready", c), 32'(bus.req_ready), 32'd0);
    end
    chk("hold load_pulses", 32'(ld_cnt - ld0), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("hold release resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("hold release req_ready", 32'(bus.req_ready), 32'd1);

    // Asynchronous reset while an SB sits in its write cycle
    st0 = st_cnt;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'h00000048, 32'h00000077);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("rstwr rd strobe", 32'(bus.mem_is_load), 32'd1);
    @(posedge clk);
    #1;
    chk("rstwr wr strobe", 32'(bus.mem_is_store), 32'd1);
    chk("rstwr wr data", bus.mem_store_data, 32'h11223377);
    rst_n = 1'b0;
    #1;
    chk("rstwr store dropped", 32'(bus.mem_is_store), 32'd0);
    chk("rstwr load dropped", 32'(bus.mem_is_load), 32'd0);
    chk("rstwr resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstwr resp_rdata", bus.resp_rdata, 32'd0);
    chk("rstwr resp_err", 32'(bus.resp_err), 32'd0);
    chk("rstwr mem_addr", bus.mem_addr, 32'd0);
    chk("rstwr mem_store_data", bus.mem_store_data, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rstwr no write", 32'(st_cnt - st0), 32'd0);
    chk("rstwr mem word", mem[12'h012], 32'h11223344);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstwr req_ready", 32'(bus.req_ready), 32'd1);
    v.ld = 1'b1; v.st = 1'b0; v.f3 = 3'b010; v.addr = 32'h48; v.wdata = 32'h0;
    v.rdata = 32'h11223344; v.err = 1'b0; v.lat = 2; v.nrd = 1; v.nwr = 0;
    v.wword = 32'h0;
    do_req("rstwr readback", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
